// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalizer.
//   M       : stored mantissa width (hidden bit excluded)
//   E       : biased exponent width
//   EXP_MAX : all-ones exponent (Inf/NaN encoding)
//   state_e : normalizer FSM states
package fp_pkg;

    localparam int unsigned M       = 10;
    localparam int unsigned E       = 5;
    localparam int unsigned EXP_MAX = (1 << E) - 1;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/fp_normalizer.sv
// Normalizes a raw adder sum into a stored mantissa and biased exponent.
// A carry is absorbed with a single right shift. A missing hidden bit is
// recovered one left shift per cycle, flushing to zero when the exponent
// would drop below 1.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   set      : start request, sampled only while idle
//   in_mant  : raw sum, bit M+1 = carry, bit M = hidden position
//   in_exp   : raw biased exponent
//   in_sign  : raw sign
//   c        : normalized stored mantissa
//   c_exp    : normalized biased exponent
//   c_sign   : result sign
//   busy     : high whenever not idle
//   done     : one-cycle pulse, result valid
//   ovf      : overflow flag, held with the result
//   unf      : underflow/flush flag, held with the result
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned M = fp_pkg::M,
    parameter int unsigned E = fp_pkg::E
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set,
    input  logic [M+1:0] in_mant,
    input  logic [E-1:0] in_exp,
    input  logic         in_sign,
    output logic [M-1:0] c,
    output logic [E-1:0] c_exp,
    output logic         c_sign,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         unf
);

    localparam logic [E-1:0] ExpOnes = {E{1'b1}};
    localparam logic [E-1:0] ExpOvf  = {{(E-1){1'b1}}, 1'b0};
    localparam logic [E-1:0] ExpOne  = {{(E-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [M+1:0] mant_q, mant_d;
    logic [E-1:0] exp_q, exp_d;
    logic         sign_q, sign_d;
    logic [M-1:0] c_q, c_d;
    logic [E-1:0] c_exp_q, c_exp_d;
    logic         c_sign_q, c_sign_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic [M+1:0] mant_shl;
    logic [E-1:0] exp_dec;

    assign mant_shl = {mant_q[M:0], 1'b0};
    assign exp_dec  = exp_q - ExpOne;

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        c_d      = c_q;
        c_exp_d  = c_exp_q;
        c_sign_d = c_sign_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        unique case (state_q)
            StIdle: begin
                if (set) begin
                    mant_d  = in_mant;
                    exp_d   = in_exp;
                    sign_d  = in_sign;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = StCheck;
                end
            end

            StCheck: begin
                c_sign_d = sign_q;
                state_d  = StDone;
                if (exp_q == ExpOnes) begin
                    // Inf/NaN pass through untouched
                    c_d     = mant_q[M-1:0];
                    c_exp_d = exp_q;
                end else if (mant_q == '0) begin
                    c_d     = '0;
                    c_exp_d = '0;
                end else if (mant_q[M+1] && (exp_q == ExpOvf)) begin
                    c_d     = '0;
                    c_exp_d = ExpOnes;
                    ovf_d   = 1'b1;
                end else if (mant_q[M+1]) begin
                    c_d     = mant_q[M:1];
                    c_exp_d = exp_q + ExpOne;
                end else if (mant_q[M]) begin
                    c_d     = mant_q[M-1:0];
                    c_exp_d = exp_q;
                end else begin
                    state_d = StShift;
                end
            end

            StShift: begin
                // Exponent 0 is treated like 1 so the decrement can never wrap.
                if (exp_q <= ExpOne) begin
                    c_d     = '0;
                    c_exp_d = '0;
                    unf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    mant_d = mant_shl;
                    exp_d  = exp_dec;
                    // Look ahead at the shifted value so the cycle that restores
                    // the hidden bit also commits the result.
                    if (mant_shl[M]) begin
                        c_d     = mant_shl[M-1:0];
                        c_exp_d = exp_dec;
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            c_q      <= '0;
            c_exp_q  <= '0;
            c_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            c_q      <= c_d;
            c_exp_q  <= c_exp_d;
            c_sign_q <= c_sign_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign c      = c_q;
    assign c_exp  = c_exp_q;
    assign c_sign = c_sign_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule
